// File: rtl/flopr.sv
// rtl/flopr.sv - parameterized register pipeline with synchronous active-high reset
module flopr #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 1 || STAGES < 1 || STAGES > 16) begin : g_bad_params
            $error("flopr: illegal WIDTH or STAGES parameter");
        end
    endgenerate

    // stage[0] captures d; stage[STAGES-1] drives q directly.
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: tb/tb_flopr.sv
// tb/tb_flopr.sv - randomized check of flopr against a queue-based delay-line model
module tb_flopr;

    localparam int         S0  = 1;
    localparam logic [31:0] RV0 = 32'h0;
    localparam int         S1  = 3;
    localparam logic [7:0] RV1 = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] d0 = '0;
    logic [31:0] q0;
    logic [7:0]  d1 = '0;
    logic [7:0]  q1;

    int checks = 0;
    int errors = 0;

    logic [31:0] m0[$];
    logic [7:0]  m1[$];
    logic [31:0] exp0;
    logic [7:0]  exp1;

    flopr u_dflt (
        .clk   (clk),
        .reset (reset),
        .d     (d0),
        .q     (q0)
    );

    flopr #(.WIDTH(8), .RESET_VALUE(RV1), .STAGES(S1)) u_par (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: each queue is the ordered content of the pipeline, newest first;
    // the output is whatever sits at the oldest end.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            m0.delete();
            m1.delete();
            for (int s = 0; s < S0; s++) m0.push_front(RV0);
            for (int s = 0; s < S1; s++) m1.push_front(RV1);
        end else begin
            m0.push_front(d0);
            void'(m0.pop_back());
            m1.push_front(d1);
            void'(m1.pop_back());
        end
        exp0 = m0[m0.size()-1];
        exp1 = m1[m1.size()-1];
        #2;
        check({tag, "_q0"}, q0, exp0);
        check({tag, "_q1"}, {24'h0, q1}, {24'h0, exp1});
    endtask

    logic [31:0] stream_vals [3] = '{32'h12153524, 32'hC0895E81, 32'h8484D609};
    logic [31:0] bit_vals    [3] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000001};
    logic [7:0]  par_exp     [5] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03};

    initial begin
        #2;
        reset = 1'b1; d0 = '0; d1 = '0;
        tick("reset");
        check("reset_q0_const", q0, 32'h0);
        check("reset_q1_const", {24'h0, q1}, 32'h000000A5);

        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d0 = (i < 3) ? stream_vals[i] : $urandom;
            d1 = 8'($urandom_range(255));
            tick("stream");
            check("stream_lat1", q0, d0);
        end

        reset = 1'b1;
        tick("par_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d1 = (i < 3) ? 8'(i + 1) : 8'h00;
            d0 = $urandom;
            tick("par_seq");
            check("par_seq_const", {24'h0, q1}, {24'h0, par_exp[i]});
        end

        d0 = 32'hDEADBEEF; d1 = 8'h77;
        reset = 1'b1;
        tick("mid_reset");
        check("mid_reset_const", q0, 32'h0);
        reset = 1'b0; d0 = 32'h0000ABCD; d1 = 8'h11;
        tick("post_reset");
        check("post_reset_const", q0, 32'h0000ABCD);
        check("post_reset_flush", {24'h0, q1}, 32'h000000A5);

        d0 = 32'h5A5A5A5A;
        tick("sync_pre");
        reset = 1'b1; #3; reset = 1'b0; #3;
        check("sync_q0", q0, exp0);
        check("sync_q1", {24'h0, q1}, {24'h0, exp1});
        d0 = 32'h01234567;
        tick("sync_post");

        for (int i = 0; i < 3; i++) begin
            d0 = bit_vals[i];
            tick("bits");
            check("bits_const", q0, bit_vals[i]);
        end

        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(15) == 0);
            d0 = $urandom;
            d1 = 8'($urandom_range(255));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
